// File: rtl/pitch_detect_pkg.sv
// Shared definitions for the pitch detector and the note oscillator.
// Holds the half-period table T(n) so both sides decode the same note map.
// OSC_CNT_BW sets the counter width (defaults to 14 bits when undefined).
`ifndef OSC_CNT_BW
`define OSC_CNT_BW 14
`endif

package pitch_detect_pkg;

  localparam int unsigned PD_CNT_BW   = `OSC_CNT_BW;
  localparam int unsigned PD_NOTE_W   = 8;
  localparam int unsigned PD_NOTE_MAX = 127;

  // Half-period compare value for MIDI note n. The lowest octave (notes 0..11)
  // is tabulated in clock cycles; every higher octave halves it. The osc counter
  // runs 0..T(n), so one half-period lasts T(n)+1 cycles.
  function automatic logic [PD_CNT_BW-1:0] note_half_period(input logic [6:0] note);
    int unsigned n;
    int unsigned base;
    n = 32'(note);
    case (n % 32'd12)
      32'd0:   base = 32'd15296;
      32'd1:   base = 32'd14431;
      32'd2:   base = 32'd13621;
      32'd3:   base = 32'd12856;
      32'd4:   base = 32'd12135;
      32'd5:   base = 32'd11454;
      32'd6:   base = 32'd10811;
      32'd7:   base = 32'd10204;
      32'd8:   base = 32'd9632;
      32'd9:   base = 32'd9091;
      32'd10:  base = 32'd8581;
      default: base = 32'd8099;
    endcase
    return PD_CNT_BW'((base >> (n / 32'd12)) - 32'd1);
  endfunction

endpackage

// File: rtl/pitch_detect_edge_meas.sv
// Input front end: synchronizes wave_i, detects both edges and counts the
// cycles since the last edge. The counter sticks at all-ones; that is the
// timeout. An edge in the saturated cycle suppresses the timeout.
module pitch_detect_edge_meas
  import pitch_detect_pkg::*;
#(
  parameter int unsigned CNT_BW = PD_CNT_BW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wave_i,
  output logic              edge_o,
  output logic [CNT_BW-1:0] cnt_o,
  output logic              timeout_o
);

  logic              sync1_q, sync2_q, prev_q;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic              sat;

  assign edge_o    = sync2_q ^ prev_q;
  assign sat       = &cnt_q;
  assign timeout_o = sat & ~edge_o;
  assign cnt_o     = cnt_q;

  // Counter restarts at 1 after an edge, otherwise counts up until it saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_o) begin
      cnt_d = {{(CNT_BW-1){1'b0}}, 1'b1};
    end else if (!sat) begin
      cnt_d = cnt_q + {{(CNT_BW-1){1'b0}}, 1'b1};
    end
  end

  // Two-flop synchronizer, previous-level register and period counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= wave_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pitch_detect.sv
// Measures the half-period of a square wave and reports the nearest MIDI note.
// A latched interval is compared against T(n)+1 for notes 0..NOTE_MAX, one per cycle.
// Optional PITCH_HYST_EN: a note is reported only after two identical decodes.
module pitch_detect
  import pitch_detect_pkg::*;
#(
  parameter int unsigned CNT_BW   = PD_CNT_BW,
  parameter int unsigned NOTE_MAX = PD_NOTE_MAX
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 wave_i,
  output logic [PD_NOTE_W-1:0] note_o,
  output logic                 valid_o,
  output logic                 locked_o
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEASURE, S_SEARCH, S_REPORT} state_e;

  localparam logic [CNT_BW:0] ERR_ONE = {{CNT_BW{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              edge_s, timeout_s;
  logic [CNT_BW-1:0] cnt_s;
  logic [CNT_BW-1:0] meas_q, meas_d;
  logic [6:0]        idx_q, idx_d, best_q, best_d, note_q, note_d;
  logic [CNT_BW:0]   best_err_q, best_err_d, err, m_ext, t_ext;
  logic              valid_q, valid_d, locked_q, locked_d;
`ifdef PITCH_HYST_EN
  logic [6:0]        prev_q, prev_d;
  logic              seed_q, seed_d;
`endif

  pitch_detect_edge_meas #(.CNT_BW(CNT_BW)) u_edge_meas (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wave_i    (wave_i),
    .edge_o    (edge_s),
    .cnt_o     (cnt_s),
    .timeout_o (timeout_s)
  );

  assign note_o   = {1'b0, note_q};
  assign valid_o  = valid_q;
  assign locked_o = locked_q;

  // Distance between the measured interval and the interval of note idx_q;
  // one extra bit keeps T(n)+1 from wrapping.
  always_comb begin
    m_ext = {1'b0, meas_q};
    t_ext = {1'b0, CNT_BW'(note_half_period(idx_q))} + ERR_ONE;
    err   = (m_ext >= t_ext) ? (m_ext - t_ext) : (t_ext - m_ext);
  end

  // Search FSM: next state, best-match tracking and output updates.
  always_comb begin
    state_d    = state_q;
    meas_d     = meas_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_err_d = best_err_q;
    note_d     = note_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
`ifdef PITCH_HYST_EN
    prev_d     = prev_q;
    seed_d     = seed_q;
`endif
    if (!enable_i) begin
      state_d  = S_IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
        end
        S_ARM: begin
          // The arming edge only restarts the counter.
          if (edge_s) state_d = S_MEASURE;
          else if (timeout_s) locked_d = 1'b0;
        end
        S_MEASURE: begin
          if (edge_s) begin
            meas_d  = cnt_s;
            idx_d   = '0;
            state_d = S_SEARCH;
          end else if (timeout_s) begin
            state_d  = S_ARM;
            locked_d = 1'b0;
          end
        end
        S_SEARCH: begin
          // Strictly-smaller update keeps the lower note on ties.
          if (idx_q == '0 || err < best_err_q) begin
            best_d     = idx_q;
            best_err_d = err;
          end
          if (timeout_s) begin
            state_d  = S_ARM;
            locked_d = 1'b0;
          end else if (idx_q == NOTE_MAX[6:0]) begin
            state_d = S_REPORT;
`ifdef PITCH_HYST_EN
            if (seed_q && best_d == prev_q) begin
              note_d   = best_d;
              valid_d  = 1'b1;
              locked_d = 1'b1;
            end
            prev_d = best_d;
            seed_d = 1'b1;
`else
            note_d   = best_d;
            valid_d  = 1'b1;
            locked_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
        S_REPORT: begin
          if (timeout_s) begin
            state_d  = S_ARM;
            locked_d = 1'b0;
          end else begin
            state_d = S_MEASURE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef PITCH_HYST_EN
    // A fresh lock must see two matching decodes again.
    if (state_d == S_IDLE || state_d == S_ARM) seed_d = 1'b0;
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      meas_q     <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_err_q <= '0;
      note_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
`ifdef PITCH_HYST_EN
      prev_q     <= '0;
      seed_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      meas_q     <= meas_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_err_q <= best_err_d;
      note_q     <= note_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
`ifdef PITCH_HYST_EN
      prev_q     <= prev_d;
      seed_q     <= seed_d;
`endif
    end
  end

endmodule

// File: doc/pitch_detect.md
Name: pitch_detect

Overview:
Receive-side counterpart of the note oscillator: measures the half-period of an incoming square wave and reports the nearest MIDI note.
Used for loopback self-test of osc and for tuning external inputs.
Edge-to-edge clock counts are compared against the same half-period table that drives osc.
A note is reported with a one-cycle valid strobe; a lock flag tracks signal presence.

Parameters:
CNT_BW, `OSC_CNT_BW, width of the period counter; must equal the osc counter width.
NOTE_MAX, 127, highest MIDI note searched (notes 0..NOTE_MAX).

Ports:
clk_i  in  1  system clock; the only clock.
rst_i  in  1  asynchronous, active-high reset.
enable_i  in  1  detector enable; low holds the FSM in IDLE.
wave_i  in  1  square wave input; asynchronous to clk_i.
note_o  out  8  detected MIDI note; bit 7 always 0.
valid_o  out  1  one-cycle strobe; note_o is updated in the same cycle.
locked_o  out  1  high while edges arrive within timeout.

Behaviour:
- Reset (rst_i=1, async): note_o=0, valid_o=0, locked_o=0, FSM=IDLE, counters=0, synchronizer=0.
- Input path: 2-flop synchronizer on wave_i, then a registered edge detector. Rising and falling edges both count, because osc toggles every half-period.
- Period counter: counts clk_i cycles since the last detected edge.
  - Restarts at 1 in the cycle after an edge.
  - Saturates at all-ones; saturation is the timeout.
- A note n in the table produces an edge interval of T(n)+1 cycles. T(n) is the osc compare value, because the osc counter runs 0..T(n) before it toggles.
- FSM states:
  - IDLE: enable_i=1 -> ARM.
  - ARM: first edge restarts the counter -> MEASURE. No measurement is made on this edge.
  - MEASURE: on edge in cycle E, latch M = counter value -> SEARCH. On saturation -> ARM, with locked_o=0.
  - SEARCH: cycles E+1..E+NOTE_MAX+1 visit notes 0..NOTE_MAX, one per cycle.
    - Each cycle computes err = |M - (T(n)+1)| at CNT_BW+1 bits, unsigned, with no overflow.
    - best is updated only on strictly smaller err, so ties go to the lower note.
    - Then -> REPORT.
  - REPORT: one cycle (E+NOTE_MAX+2). note_o=best, valid_o=1, locked_o=1 -> MEASURE.
- Period counting continues during SEARCH/REPORT.
  - Edges arriving during SEARCH/REPORT restart the counter but are not latched; that sample is dropped.
  - On returning to MEASURE, the next edge latches a fresh M.
- Timeout in any non-IDLE state: locked_o=0 in the cycle after saturation, FSM -> ARM, note_o holds its last value.
- enable_i=0: synchronous, takes effect next cycle. FSM -> IDLE, valid_o=0, locked_o=0, note_o holds, any search is aborted.
- rst_i mid-search: immediate return to reset values; no valid_o is emitted.
- Simultaneous edge and saturation: the edge wins; M = all-ones is measured normally.
- valid_o is never high on two consecutive cycles.

Optional Feature:
PITCH_HYST_EN.
- Defined: REPORT updates note_o and pulses valid_o only if best equals the previous search result, i.e. two consecutive identical decodes are required.
  - The first result after ARM only seeds the comparison register.
  - locked_o rises with the first emitted valid_o.
- Undefined: every search result is reported as described above.

Decomposition:
- Shared package/include: half-period table function T(n) (CNT_BW-wide, notes 0..127), NOTE_W=8, NOTE_MAX. The same function is used by note2cnt so osc and detector cannot diverge.
- FSM state encoding is local.
- One sub-module: edge_meas. It holds the synchronizer, edge detect and saturating period counter, and outputs edge strobe, count and timeout.
- The search FSM lives in pitch_detect.

Test Plan:
1. Loopback osc(note 69) into wave_i -> after the ARM edge plus 2nd edge E, valid_o=1 at E+129 with note_o=69, locked_o=1. The strobe repeats every measured half-period plus dropped edges.
2. Ideal wave with interval exactly midway between T(60)+1 and T(61)+1 (integer midpoint) -> note_o=60 (tie to lower note). Interval 1 cycle shorter -> 61.
3. Interval far above T(0)+1 -> note_o=0. Interval 2 cycles (below T(127)+1) -> note_o=127.
4. wave_i held constant for 2^CNT_BW cycles after lock -> locked_o=0 one cycle after saturation, note_o retained, no valid_o. Edges resuming -> first edge arms only.
5. rst_i pulse and, separately, enable_i=0 at E+50 during SEARCH -> no valid_o. Reset case: note_o=0. Enable case: note_o unchanged, FSM IDLE.
6. PITCH_HYST_EN defined, alternating intervals for notes 60/61 -> no valid_o. Steady 60 -> first valid_o only after the second identical decode.
